// File: rtl/freq_gen.sv
// freq_gen: switching-frequency generator for a complementary half-bridge.
// It holds the active switching period and applies optimiser step requests
// only at switching-cycle boundaries, so a gate pulse is never cut short.
// Both gate outputs are decoded with a fixed dead time.
// Optional soft start: define FREQ_GEN_SOFTSTART_EN. The period then ramps
// from PER_MAX down to PER_INIT before any optimiser request is accepted.
//
// Handshake: freq_ready and freq_opt are single-cycle strobes, sampled on
// the rising clk edge. No back-pressure exists. A freq_ready is captured as a
// pending step, and only the last capture before a boundary is applied.
// cycle_start is a one-cycle pulse aligned with cnt == 0. The new
// period_out becomes visible in that same cycle.
module freq_gen #(
  parameter int PER_INIT = 1250,
  parameter int PER_MIN  = 1000,
  parameter int PER_MAX  = 1667,
  parameter int STEP     = 5,
  parameter int DEAD     = 25
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freq_ready,
  input  logic        freq_set_up_down,
  input  logic        freq_opt,
  output logic [15:0] period_out,
  output logic        gate_hi,
  output logic        gate_lo,
  output logic        cycle_start,
  output logic        locked,
  output logic [1:0]  state_dbg
);

  localparam logic [1:0] S_TRACK = 2'd1;
  localparam logic [1:0] S_LOCK  = 2'd2;
`ifdef FREQ_GEN_SOFTSTART_EN
  localparam logic [1:0]  S_RAMP    = 2'd0;
  localparam logic [1:0]  S_RESET   = S_RAMP;
  localparam logic [15:0] PER_RESET = 16'(PER_MAX);
`else
  localparam logic [1:0]  S_RESET   = S_TRACK;
  localparam logic [15:0] PER_RESET = 16'(PER_INIT);
`endif

  logic [1:0]  r_state;
  logic [15:0] r_period;
  logic [15:0] r_cnt;
  logic        r_run;          // low only between reset release and first edge
  logic        r_pend_valid;
  logic        r_pend_dir;
  logic        r_gate_hi;
  logic        r_gate_lo;
  logic        r_cycle_start;

  logic        w_boundary;
  logic [15:0] w_cnt_next;
  logic [16:0] w_sum;
  logic [15:0] w_diff;
  logic [15:0] w_per_up;
  logic [15:0] w_per_dn;
  logic [1:0]  w_state_next;
  logic [15:0] w_per_next;
  logic        w_pend_valid_next;
  logic        w_pend_dir_next;
  logic [15:0] w_half_next;
  logic        w_gate_hi_next;
  logic        w_gate_lo_next;
`ifdef FREQ_GEN_SOFTSTART_EN
  logic [15:0] w_per_ramp;
`endif

  // Counter advance and clamped step arithmetic.
  // The lower clamp is decided in 17 bits, so the subtraction cannot wrap.
  always_comb begin
    w_boundary = r_run && (r_cnt == (r_period - 16'd1));
    if (!r_run || w_boundary) w_cnt_next = 16'd0;
    else                      w_cnt_next = r_cnt + 16'd1;
    w_sum    = {1'b0, r_period} + 17'(STEP);
    w_diff   = r_period - 16'(STEP);
    w_per_up = ({1'b0, r_period} < 17'(PER_MIN + STEP)) ? 16'(PER_MIN) : w_diff;
    w_per_dn = (w_sum > 17'(PER_MAX)) ? 16'(PER_MAX) : w_sum[15:0];
`ifdef FREQ_GEN_SOFTSTART_EN
    w_per_ramp = ({1'b0, r_period} < 17'(PER_INIT + STEP)) ? 16'(PER_INIT) : w_diff;
`endif
  end

  // Mode FSM, pending-request capture and period update at the boundary.
  always_comb begin
    w_state_next      = r_state;
    w_per_next        = r_period;
    w_pend_valid_next = r_pend_valid;
    w_pend_dir_next   = r_pend_dir;
    case (r_state)
`ifdef FREQ_GEN_SOFTSTART_EN
      S_RAMP: begin
        if (w_boundary) begin
          w_per_next = w_per_ramp;
          if (w_per_ramp == 16'(PER_INIT)) w_state_next = S_TRACK;
        end
      end
`endif
      S_TRACK: begin
        if (w_boundary && r_pend_valid) begin
          w_per_next        = r_pend_dir ? w_per_up : w_per_dn;
          w_pend_valid_next = 1'b0;
        end
        if (freq_opt) begin
          w_state_next      = S_LOCK;
          w_pend_valid_next = 1'b0;
        end else if (freq_ready) begin
          w_pend_valid_next = 1'b1;
          w_pend_dir_next   = freq_set_up_down;
        end
      end
      S_LOCK: begin
        if (freq_opt) begin
          w_pend_valid_next = 1'b0;
        end else if (freq_ready) begin
          w_state_next      = S_TRACK;
          w_pend_valid_next = 1'b1;
          w_pend_dir_next   = freq_set_up_down;
        end
      end
      default: w_state_next = S_RESET;
    endcase
  end

  // Gate windows are decoded from the counter value about to be loaded.
  // The registered outputs therefore line up exactly with cnt.
  always_comb begin
    w_half_next    = w_per_next >> 1;
    w_gate_hi_next = (w_cnt_next >= 16'(DEAD)) && (w_cnt_next < w_half_next);
    w_gate_lo_next = (w_cnt_next >= (w_half_next + 16'(DEAD))) &&
                     (w_cnt_next < w_per_next);
  end

  // State and output registers. Reset forces the gates low immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_RESET;
      r_period      <= PER_RESET;
      r_cnt         <= 16'd0;
      r_run         <= 1'b0;
      r_pend_valid  <= 1'b0;
      r_pend_dir    <= 1'b0;
      r_gate_hi     <= 1'b0;
      r_gate_lo     <= 1'b0;
      r_cycle_start <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_period      <= w_per_next;
      r_cnt         <= w_cnt_next;
      r_run         <= 1'b1;
      r_pend_valid  <= w_pend_valid_next;
      r_pend_dir    <= w_pend_dir_next;
      r_gate_hi     <= w_gate_hi_next;
      r_gate_lo     <= w_gate_lo_next;
      r_cycle_start <= (w_cnt_next == 16'd0);
    end
  end

  assign period_out  = r_period;
  assign gate_hi     = r_gate_hi;
  assign gate_lo     = r_gate_lo;
  assign cycle_start = r_cycle_start;
  assign locked      = (r_state == S_LOCK);
  assign state_dbg   = r_state;

endmodule

// File: tb/tb_freq_gen.sv
// tb_freq_gen: table-driven request vectors, a scoreboard of expected
// {locked, period} values popped at each cycle_start, and a per-cycle gate
// window monitor.
module tb_freq_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        freq_ready = 1'b0;
  logic        freq_set_up_down = 1'b0;
  logic        freq_opt = 1'b0;
  logic [15:0] period_out;
  logic        gate_hi;
  logic        gate_lo;
  logic        cycle_start;
  logic        locked;
  logic [1:0]  state_dbg;

  // clock / reset block
  always #10 clk = ~clk;

  freq_gen dut (
    .clk(clk), .rst(rst), .freq_ready(freq_ready),
    .freq_set_up_down(freq_set_up_down), .freq_opt(freq_opt),
    .period_out(period_out), .gate_hi(gate_hi), .gate_lo(gate_lo),
    .cycle_start(cycle_start), .locked(locked), .state_dbg(state_dbg)
  );

  typedef struct {
    bit r0; bit d0; bit o0;   // strobes near cnt 100
    bit r1; bit d1; bit o1;   // strobes two clocks later
    int exp_per;
    bit exp_lock;
  } vec_t;

  vec_t        vecs[10];
  logic [16:0] exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  bit          mon_en = 0;
  bit          m_valid = 0;
  int          m_cnt = 0;
  int          m_len = 0;
  int          m_bad = 0;
  int          exp_cur;
  bit          ok;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Gate window monitor: one sample per clock, one verdict per cycle.
  task automatic mon_step();
    bit eh;
    bit el;
    if (cycle_start) begin
      if (m_valid) begin
        chk("cycle_len", m_cnt + 1, m_len);
        chk("gate_window_errs", m_bad, 0);
      end
      m_cnt = 0; m_len = int'(period_out); m_bad = 0; m_valid = 1;
    end else if (m_valid) begin
      m_cnt++;
    end
    if (m_valid) begin
      eh = (m_cnt >= 25) && (m_cnt < m_len / 2);
      el = (m_cnt >= m_len / 2 + 25) && (m_cnt < m_len);
      if (gate_hi !== eh || gate_lo !== el || (gate_hi && gate_lo) ||
          int'(period_out) != m_len)
        m_bad++;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (mon_en) mon_step();
  endtask

  task automatic wait_cs(output bit got);
    got = 0;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (cycle_start) begin
        got = 1;
        break;
      end
    end
    if (!got) chk("cs_timeout", int'(cycle_start), 1);
  endtask

  task automatic sb_pop();
    logic [16:0] e;
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    chk("period_at_cs", int'(period_out), int'(e[15:0]));
    chk("locked_at_cs", int'(locked), int'(e[16]));
  endtask

  task automatic pulse(input bit r, input bit d, input bit o);
    freq_ready = r; freq_set_up_down = d; freq_opt = o;
    tick();
    freq_ready = 0; freq_opt = 0;
  endtask

  initial begin
    vecs[0] = '{1, 1, 0, 0, 0, 0, 1245, 0};  // one up step
    vecs[1] = '{1, 0, 0, 0, 0, 0, 1250, 0};  // one down step
    vecs[2] = '{1, 1, 0, 1, 0, 0, 1255, 0};  // up then down: last wins
    vecs[3] = '{1, 1, 1, 0, 0, 0, 1255, 1};  // opt beats same-cycle request
    vecs[4] = '{1, 1, 0, 0, 0, 0, 1250, 0};  // request in lock: unlock + step
    vecs[5] = '{0, 0, 1, 0, 0, 0, 1250, 1};  // lock
    vecs[6] = '{0, 0, 1, 0, 0, 0, 1250, 1};  // opt while locked: no effect
    vecs[7] = '{1, 0, 0, 0, 0, 0, 1255, 0};  // unlock with down step
    vecs[8] = '{0, 0, 1, 1, 1, 0, 1250, 0};  // lock, then up request unlocks
    vecs[9] = '{1, 0, 0, 0, 0, 1, 1250, 1};  // pending request dropped by opt

    // reset state
    repeat (3) tick();
    chk("rst_gate_hi", int'(gate_hi), 0);
    chk("rst_gate_lo", int'(gate_lo), 0);
    chk("rst_cycle_start", int'(cycle_start), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_period", int'(period_out), 1250);

    rst = 0;
    mon_en = 1;
    tick();
    chk("first_cs", int'(cycle_start), 1);
    exp_cur = 1250;
    exp_q.push_back({1'b0, 16'd1250});
    wait_cs(ok);
    if (ok) sb_pop();

    // table-driven request vectors, one switching cycle each
    for (int i = 0; i < 10; i++) begin
      repeat (99) tick();
      pulse(vecs[i].r0, vecs[i].d0, vecs[i].o0);
      tick();
      pulse(vecs[i].r1, vecs[i].d1, vecs[i].o1);
      chk("period_hold", int'(period_out), exp_cur);
      exp_q.push_back({logic'(vecs[i].exp_lock), 16'(vecs[i].exp_per)});
      wait_cs(ok);
      if (ok) sb_pop();
      exp_cur = vecs[i].exp_per;
    end

    // locked timing: falls and rises one clock after the strobe
    repeat (50) tick();
    pulse(1, 0, 0);
    chk("unlock_1clk", int'(locked), 0);
    repeat (20) tick();
    pulse(0, 0, 1);
    chk("lock_1clk", int'(locked), 1);
    repeat (20) tick();
    pulse(1, 1, 0);
    chk("unlock2_1clk", int'(locked), 0);
    chk("period_hold_lock", int'(period_out), exp_cur);
    exp_cur = exp_cur - 5;
    exp_q.push_back({1'b0, 16'(exp_cur)});
    wait_cs(ok);
    if (ok) sb_pop();

    // saturation at the minimum period
    for (int k = 0; k < 51; k++) begin
      repeat (5) tick();
      pulse(1, 1, 0);
      exp_cur = (exp_cur - 5 < 1000) ? 1000 : exp_cur - 5;
      exp_q.push_back({1'b0, 16'(exp_cur)});
      wait_cs(ok);
      if (ok) sb_pop();
    end

    // asynchronous reset in the middle of the high-side pulse
    repeat (300) tick();
    chk("pre_rst_gate_hi", int'(gate_hi), 1);
    mon_en = 0;
    #1 rst = 1;
    #1;
    chk("async_gate_hi", int'(gate_hi), 0);
    chk("async_gate_lo", int'(gate_lo), 0);
    tick();
    chk("rst2_period", int'(period_out), 1250);
    chk("rst2_locked", int'(locked), 0);
    chk("rst2_cycle_start", int'(cycle_start), 0);
    rst = 0;
    m_valid = 0;
    mon_en = 1;
    tick();
    chk("first_cs2", int'(cycle_start), 1);
    exp_q.push_back({1'b0, 16'd1250});
    wait_cs(ok);
    if (ok) sb_pop();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
